rf_tx_regbank_mc: RTL and testbench

// - Multi-channel successor of the single-channel SPI-side register file: N_CH RF TX channels behind one byte-wide
//   SPI slave register port, each with ctrl, status, TX_DATA_W payload and a start/done handshake FSM.
// - Adds shadow payload latching, overrun/timeout detection, sticky W1C status and a combined irq.
// - Sits between spi_slave (o_rf_wre/o_rf_addr/o_dout/i_rf_din) and the RF TX engines, all in the SPI clock domain.

---
 rtl/rf_tx_regbank_mc_pkg.sv | 34 +++
 rtl/rf_tx_chan_ctrl.sv | 128 ++++++++++++
 rtl/rf_tx_regbank_mc.sv | 117 +++++++++++
 tb/tb_rf_tx_regbank_mc.sv | 354 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/rf_tx_regbank_mc_pkg.sv
// rf_tx_pkg: shared register map constants and channel FSM state type for
// the multi-channel RF TX register bank.
//   - channel stride and per-channel register offsets (CTRL / STATUS / DATA)
//   - CTRL and STATUS bit positions
//   - global read-only register addresses and the ID low nibble
package rf_tx_pkg;

    localparam int CH_STRIDE = 16;

    localparam logic [3:0] OFF_CTRL   = 4'd0;
    localparam logic [3:0] OFF_STATUS = 4'd1;
    localparam logic [3:0] OFF_DATA   = 4'd2;

    localparam int CTRL_START  = 0;
    localparam int CTRL_MODE   = 1;
    localparam int CTRL_PD     = 2;
    localparam int CTRL_IRQ_EN = 3;

    localparam int ST_BUSY     = 0;
    localparam int ST_DONE     = 1;
    localparam int ST_OVERRUN  = 2;
    localparam int ST_TIMEOUT  = 3;

    localparam int ADDR_ID  = 'hF0;
    localparam int ADDR_IRQ = 'hF1;

    localparam logic [3:0] ID_LO = 4'h2;

    typedef enum logic {
        CH_IDLE = 1'b0,
        CH_BUSY = 1'b1
    } chan_state_e;

endpackage

// File: rtl/rf_tx_chan_ctrl.sv
// rf_tx_chan_ctrl: one RF TX channel -- CTRL/DATA registers, start/done
// handshake FSM, busy timeout counter, sticky W1C status and payload shadow.
// Ports:
//   clk, resetn                 clock, async active-low reset
//   ctrl_we/status_we/data_we   decoded write strobes for this channel
//   data_idx, wr_data           DATA byte index and write byte
//   rf_tx_done                  done from TX engine (ignored when idle)
//   rf_tx_start/mode/power_domain, rf_tx_data   engine-facing outputs
//   data_rd, ctrl_rd, stat_rd   readback values for the top-level mux
//   irq_pend                    (done|timeout) & irq_en
//
// state   | meaning
// CH_IDLE | waiting for a CTRL write with start=1
// CH_BUSY | start held high, waiting for done or timeout
module rf_tx_chan_ctrl
    import rf_tx_pkg::*;
#(
    parameter int TX_DATA_W = 32,
    parameter int TIMEOUT   = 255
) (
    input  logic                 clk,
    input  logic                 resetn,
    input  logic                 ctrl_we,
    input  logic                 status_we,
    input  logic                 data_we,
    input  logic [3:0]           data_idx,
    input  logic [7:0]           wr_data,
    input  logic                 rf_tx_done,
    output logic                 rf_tx_start,
    output logic                 rf_tx_mode,
    output logic                 rf_power_domain,
    output logic [TX_DATA_W-1:0] rf_tx_data,
    output logic [TX_DATA_W-1:0] data_rd,
    output logic [7:0]           ctrl_rd,
    output logic [7:0]           stat_rd,
    output logic                 irq_pend
);
    localparam int NB    = TX_DATA_W / 8;
    localparam int CNT_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [CNT_W:0] TO_LIMIT = (CNT_W + 1)'(TIMEOUT);

    chan_state_e          state_q, state_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic [TX_DATA_W-1:0] data_q, shadow_q, shadow_d;
    logic                 mode_q, pd_q, ien_q;
    logic                 done_q, done_d, ovr_q, ovr_d, to_q, to_d;
    logic                 start_req, to_hit;

    assign start_req = ctrl_we && wr_data[CTRL_START];
    // Fires on the last allowed busy cycle, so BUSY lasts exactly TIMEOUT cycles.
    assign to_hit    = (TIMEOUT != 0) && (({1'b0, cnt_q} + (CNT_W + 1)'(1)) == TO_LIMIT);

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        shadow_d = shadow_q;
        done_d   = done_q;
        ovr_d    = ovr_q;
        to_d     = to_q;
        // Clears first so a same-cycle hardware set overrides the W1C.
        if (status_we) begin
            done_d = done_q & ~wr_data[ST_DONE];
            ovr_d  = ovr_q  & ~wr_data[ST_OVERRUN];
            to_d   = to_q   & ~wr_data[ST_TIMEOUT];
        end
        case (state_q)
            CH_IDLE: begin
                if (start_req) begin
                    state_d  = CH_BUSY;
                    cnt_d    = '0;
                    shadow_d = data_q;
                end
            end
            CH_BUSY: begin
                if (cnt_q != '1) cnt_d = cnt_q + CNT_W'(1);
                if (start_req) ovr_d = 1'b1;
                if (rf_tx_done) begin
                    state_d = CH_IDLE;
                    done_d  = 1'b1;
                end else if (to_hit) begin
                    state_d = CH_IDLE;
                    to_d    = 1'b1;
                end
            end
            default: state_d = CH_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q  <= CH_IDLE;
            cnt_q    <= '0;
            shadow_q <= '0;
            done_q   <= 1'b0;
            ovr_q    <= 1'b0;
            to_q     <= 1'b0;
            mode_q   <= 1'b0;
            pd_q     <= 1'b0;
            ien_q    <= 1'b0;
            data_q   <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            shadow_q <= shadow_d;
            done_q   <= done_d;
            ovr_q    <= ovr_d;
            to_q     <= to_d;
            if (ctrl_we) begin
                mode_q <= wr_data[CTRL_MODE];
                pd_q   <= wr_data[CTRL_PD];
                ien_q  <= wr_data[CTRL_IRQ_EN];
            end
            for (int b = 0; b < NB; b++) begin
                if (data_we && (data_idx == 4'(b))) data_q[b*8 +: 8] <= wr_data;
            end
        end
    end

    assign rf_tx_start     = (state_q == CH_BUSY);
    assign rf_tx_mode      = mode_q;
    assign rf_power_domain = pd_q;
    assign rf_tx_data      = shadow_q;
    assign data_rd         = data_q;
    assign ctrl_rd         = {4'b0000, ien_q, pd_q, mode_q, 1'b0};
    assign stat_rd         = {4'b0000, to_q, ovr_q, done_q, rf_tx_start};
    assign irq_pend        = (done_q | to_q) & ien_q;

endmodule

// File: rtl/rf_tx_regbank_mc.sv
// rf_tx_regbank_mc: byte-wide SPI-side register bank for N_CH RF TX channels.
// Decodes the register address, muxes read data, pulses write_flag after a
// mapped write and ORs per-channel interrupt requests into irq.
// Ports:
//   clk, resetn                      SPI clock, async active-low reset
//   write_enable, address, wr_data   register write port
//   rd_data                          combinational read data
//   rf_tx_start/mode/power_domain    per-channel controls (one bit each)
//   rf_tx_data                       shadow payloads, channel 0 in LSBs
//   rf_tx_done                       per-channel done from TX engines
//   write_flag                       one-cycle pulse after a mapped write
//   irq                              combined interrupt
module rf_tx_regbank_mc
    import rf_tx_pkg::*;
#(
    parameter int N_CH      = 4,
    parameter int TX_DATA_W = 32,
    parameter int ADDR_W    = 8,
    parameter int TIMEOUT   = 255
) (
    input  logic                      clk,
    input  logic                      resetn,
    input  logic                      write_enable,
    input  logic [ADDR_W-1:0]         address,
    input  logic [7:0]                wr_data,
    output logic [7:0]                rd_data,
    output logic [N_CH-1:0]           rf_tx_start,
    output logic [N_CH-1:0]           rf_tx_mode,
    output logic [N_CH-1:0]           rf_power_domain,
    output logic [N_CH*TX_DATA_W-1:0] rf_tx_data,
    input  logic [N_CH-1:0]           rf_tx_done,
    output logic                      write_flag,
    output logic                      irq
);
    localparam int NB       = TX_DATA_W / 8;
    localparam int CH_SHIFT = $clog2(CH_STRIDE);

    logic [ADDR_W-CH_SHIFT-1:0] ch_idx;
    logic [3:0]                 off, data_idx;
    logic                       chan_ok, is_ctrl, is_stat, is_data, is_id, is_irq, mapped;
    logic [N_CH-1:0]            ch_hit, irq_pend;
    logic [7:0]                 ctrl_rd [N_CH];
    logic [7:0]                 stat_rd [N_CH];
    logic [TX_DATA_W-1:0]       data_rd [N_CH];
    logic                       write_flag_q;

    assign ch_idx   = address[ADDR_W-1:CH_SHIFT];
    assign off      = address[CH_SHIFT-1:0];
    assign chan_ok  = (int'(ch_idx) < N_CH);
    assign is_ctrl  = (off == OFF_CTRL);
    assign is_stat  = (off == OFF_STATUS);
    assign is_data  = (int'(off) >= int'(OFF_DATA)) && (int'(off) < int'(OFF_DATA) + NB);
    assign data_idx = off - OFF_DATA;
    assign is_id    = (address == ADDR_W'(ADDR_ID));
    assign is_irq   = (address == ADDR_W'(ADDR_IRQ));
    assign mapped   = (chan_ok && (is_ctrl || is_stat || is_data)) || is_id || is_irq;

    for (genvar c = 0; c < N_CH; c++) begin : g_chan
        assign ch_hit[c] = chan_ok && (int'(ch_idx) == c);

        rf_tx_chan_ctrl #(
            .TX_DATA_W (TX_DATA_W),
            .TIMEOUT   (TIMEOUT)
        ) u_chan (
            .clk             (clk),
            .resetn          (resetn),
            .ctrl_we         (write_enable && ch_hit[c] && is_ctrl),
            .status_we       (write_enable && ch_hit[c] && is_stat),
            .data_we         (write_enable && ch_hit[c] && is_data),
            .data_idx        (data_idx),
            .wr_data         (wr_data),
            .rf_tx_done      (rf_tx_done[c]),
            .rf_tx_start     (rf_tx_start[c]),
            .rf_tx_mode      (rf_tx_mode[c]),
            .rf_power_domain (rf_power_domain[c]),
            .rf_tx_data      (rf_tx_data[c*TX_DATA_W +: TX_DATA_W]),
            .data_rd         (data_rd[c]),
            .ctrl_rd         (ctrl_rd[c]),
            .stat_rd         (stat_rd[c]),
            .irq_pend        (irq_pend[c])
        );
    end

    always_comb begin
        rd_data = 8'h00;
        for (int c = 0; c < N_CH; c++) begin
            if (ch_hit[c]) begin
                if (is_ctrl) begin
                    rd_data = ctrl_rd[c];
                end else if (is_stat) begin
                    rd_data = stat_rd[c];
                end else begin
                    for (int b = 0; b < NB; b++) begin
                        if (is_data && (data_idx == 4'(b))) rd_data = data_rd[c][b*8 +: 8];
                    end
                end
            end
        end
        if (is_id) begin
            rd_data = {4'(N_CH), ID_LO};
        end else if (is_irq) begin
            rd_data = 8'(irq_pend);
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            write_flag_q <= 1'b0;
        end else begin
            write_flag_q <= write_enable && mapped;
        end
    end

    assign write_flag = write_flag_q;
    assign irq        = |irq_pend;

endmodule

// File: tb/tb_rf_tx_regbank_mc.sv
module tb_rf_tx_regbank_mc;
    localparam int N_CH      = 4;
    localparam int TX_DATA_W = 32;
    localparam int ADDR_W    = 8;
    localparam int TIMEOUT   = 255;
    localparam int NB        = TX_DATA_W / 8;

    localparam int K_RD    = 0;
    localparam int K_START = 1;
    localparam int K_MODE  = 2;
    localparam int K_PD    = 3;
    localparam int K_DATA  = 4;
    localparam int K_WF    = 5;
    localparam int K_IRQ   = 6;

    logic                      clk = 1'b0;
    logic                      resetn = 1'b0;
    logic                      write_enable = 1'b0;
    logic [ADDR_W-1:0]         address = '0;
    logic [7:0]                wr_data = '0;
    logic [7:0]                rd_data;
    logic [N_CH-1:0]           rf_tx_start, rf_tx_mode, rf_power_domain;
    logic [N_CH*TX_DATA_W-1:0] rf_tx_data;
    logic [N_CH-1:0]           rf_tx_done = '0;
    logic                      write_flag, irq;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    rf_tx_regbank_mc #(
        .N_CH      (N_CH),
        .TX_DATA_W (TX_DATA_W),
        .ADDR_W    (ADDR_W),
        .TIMEOUT   (TIMEOUT)
    ) dut (
        .clk             (clk),
        .resetn          (resetn),
        .write_enable    (write_enable),
        .address         (address),
        .wr_data         (wr_data),
        .rd_data         (rd_data),
        .rf_tx_start     (rf_tx_start),
        .rf_tx_mode      (rf_tx_mode),
        .rf_power_domain (rf_power_domain),
        .rf_tx_data      (rf_tx_data),
        .rf_tx_done      (rf_tx_done),
        .write_flag      (write_flag),
        .irq             (irq)
    );

    // Reference model: architectural register contents per channel.
    logic            m_busy   [N_CH];
    int              m_bcnt   [N_CH];
    logic [7:0]      m_data   [N_CH][NB];
    logic [TX_DATA_W-1:0] m_shadow [N_CH];
    logic            m_done [N_CH], m_ovr [N_CH], m_to [N_CH];
    logic            m_mode [N_CH], m_pd [N_CH], m_ien [N_CH];
    logic            m_wf;

    typedef struct {
        int           kind;
        logic [127:0] exp;
    } chk_t;
    chk_t sb_q[$];

    function automatic string kname(int k);
        case (k)
            K_RD:    return "rd_data";
            K_START: return "rf_tx_start";
            K_MODE:  return "rf_tx_mode";
            K_PD:    return "rf_power_domain";
            K_DATA:  return "rf_tx_data";
            K_WF:    return "write_flag";
            default: return "irq";
        endcase
    endfunction

    function automatic void model_reset();
        for (int c = 0; c < N_CH; c++) begin
            m_busy[c] = 0; m_bcnt[c] = 0; m_shadow[c] = '0;
            m_done[c] = 0; m_ovr[c] = 0; m_to[c] = 0;
            m_mode[c] = 0; m_pd[c] = 0; m_ien[c] = 0;
            for (int b = 0; b < NB; b++) m_data[c][b] = 8'h00;
        end
        m_wf = 0;
    endfunction

    function automatic logic is_mapped(logic [7:0] a);
        int ch  = int'(a[7:4]);
        int off = int'(a[3:0]);
        return (ch < N_CH && off < 2 + NB) || a == 8'hF0 || a == 8'hF1;
    endfunction

    function automatic logic [7:0] m_read(logic [7:0] a);
        int ch  = int'(a[7:4]);
        int off = int'(a[3:0]);
        logic [7:0] v = 8'h00;
        if (a == 8'hF0) return {4'(N_CH), 4'h2};
        if (a == 8'hF1) begin
            for (int c = 0; c < N_CH; c++) v[c] = (m_done[c] | m_to[c]) & m_ien[c];
            return v;
        end
        if (ch >= N_CH || off >= 2 + NB) return 8'h00;
        if (off == 0) return {4'h0, m_ien[ch], m_pd[ch], m_mode[ch], 1'b0};
        if (off == 1) return {4'h0, m_to[ch], m_ovr[ch], m_done[ch], m_busy[ch]};
        return m_data[ch][off-2];
    endfunction

    // Advances the model across one rising edge with the given inputs.
    function automatic void model_tick(logic we, logic [7:0] a, logic [7:0] wd, logic [N_CH-1:0] dn);
        int ch  = int'(a[7:4]);
        int off = int'(a[3:0]);
        m_wf = we && is_mapped(a);
        for (int c = 0; c < N_CH; c++) begin
            logic sel   = we && (ch == c);
            logic start = sel && off == 0 && wd[0];
            if (sel && off == 1) begin
                if (wd[1]) m_done[c] = 0;
                if (wd[2]) m_ovr[c]  = 0;
                if (wd[3]) m_to[c]   = 0;
            end
            if (m_busy[c]) begin
                if (start) m_ovr[c] = 1;
                if (dn[c]) begin
                    m_busy[c] = 0;
                    m_done[c] = 1;
                end else begin
                    m_bcnt[c]++;
                    if (TIMEOUT != 0 && m_bcnt[c] == TIMEOUT) begin
                        m_busy[c] = 0;
                        m_to[c]   = 1;
                    end
                end
            end else if (start) begin
                m_busy[c] = 1;
                m_bcnt[c] = 0;
                for (int b = 0; b < NB; b++) m_shadow[c][b*8 +: 8] = m_data[c][b];
            end
            if (sel && off == 0) begin
                m_mode[c] = wd[1]; m_pd[c] = wd[2]; m_ien[c] = wd[3];
            end
            if (sel && off >= 2 && off < 2 + NB) m_data[c][off-2] = wd;
        end
    endfunction

    function automatic void push(int k, logic [127:0] e);
        chk_t x;
        x.kind = k;
        x.exp  = e;
        sb_q.push_back(x);
    endfunction

    function automatic void push_all();
        logic [N_CH-1:0] s = '0, md = '0, p = '0;
        logic [127:0] d = '0;
        logic ir = 0;
        for (int c = 0; c < N_CH; c++) begin
            s[c] = m_busy[c]; md[c] = m_mode[c]; p[c] = m_pd[c];
            d[c*TX_DATA_W +: TX_DATA_W] = m_shadow[c];
            ir = ir | ((m_done[c] | m_to[c]) & m_ien[c]);
        end
        push(K_RD, 128'(m_read(address)));
        push(K_START, 128'(s));
        push(K_MODE, 128'(md));
        push(K_PD, 128'(p));
        push(K_DATA, d);
        push(K_WF, 128'(m_wf));
        push(K_IRQ, 128'(ir));
    endfunction

    // Monitor: compares every queued expectation against the DUT on the falling edge.
    always @(negedge clk) begin
        chk_t e;
        logic [127:0] act;
        while (sb_q.size() > 0) begin
            e = sb_q.pop_front();
            case (e.kind)
                K_RD:    act = 128'(rd_data);
                K_START: act = 128'(rf_tx_start);
                K_MODE:  act = 128'(rf_tx_mode);
                K_PD:    act = 128'(rf_power_domain);
                K_DATA:  act = 128'(rf_tx_data);
                K_WF:    act = 128'(write_flag);
                default: act = 128'(irq);
            endcase
            n_checks++;
            if (act !== e.exp) begin
                n_errors++;
                $display("FAIL %s @%0t addr=%02h: got %0h expected %0h", kname(e.kind), $time, address, act, e.exp);
            end
        end
    end

    // Called at posedge+1; returns at the next posedge+1.
    task automatic step(input logic we, input logic [7:0] a, input logic [7:0] wd, input logic [N_CH-1:0] dn);
        write_enable = we;
        address      = a;
        wr_data      = wd;
        rf_tx_done   = dn;
        push_all();
        @(negedge clk);
        model_tick(we, a, wd, dn);
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [7:0] a, input logic [7:0] d);
        step(1'b1, a, d, '0);
    endtask

    task automatic rd(input logic [7:0] a);
        step(1'b0, a, 8'h00, '0);
    endtask

    task automatic reset_step(input logic [7:0] a);
        resetn       = 1'b0;
        write_enable = 1'b0;
        address      = a;
        wr_data      = 8'h00;
        rf_tx_done   = '0;
        model_reset();
        push_all();
        @(negedge clk);
        @(posedge clk);
        #1;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached, checks=%0d", n_checks);
        $fatal(1, "watchdog");
    end

    initial begin
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        reset_step(8'h01);
        reset_step(8'hF0);
        n_checks++;
        if (rd_data !== 8'h42) begin
            n_errors++;
            $display("FAIL id under reset: got %02h expected 42", rd_data);
        end
        n_checks++;
        if (rf_tx_start !== '0) begin
            n_errors++;
            $display("FAIL rf_tx_start under reset: got %0h", rf_tx_start);
        end
        resetn = 1'b1;

        // Channel 1 payload and start
        wr(8'h12, 8'h11); wr(8'h13, 8'h22); wr(8'h14, 8'h33); wr(8'h15, 8'h44);
        wr(8'h10, 8'h01);
        n_checks++;
        if (rf_tx_start[1] !== 1'b1) begin
            n_errors++;
            $display("FAIL ch1 start not asserted after CTRL start");
        end
        n_checks++;
        if (rf_tx_data[63:32] !== 32'h44332211) begin
            n_errors++;
            $display("FAIL ch1 shadow: got %08h expected 44332211", rf_tx_data[63:32]);
        end
        rd(8'h11);
        step(1'b0, 8'h11, 8'h00, 4'b0010);
        n_checks++;
        if (rf_tx_start[1] !== 1'b0) begin
            n_errors++;
            $display("FAIL ch1 start still high after done");
        end
        rd(8'h11);
        wr(8'h11, 8'h02);
        rd(8'h11);

        // Overrun: start twice while busy, DATA rewrite must not touch shadow
        wr(8'h10, 8'h01);
        wr(8'h12, 8'h55);
        wr(8'h10, 8'h01);
        wr(8'h10, 8'h01);
        rd(8'h11);
        rd(8'h12);
        step(1'b0, 8'h11, 8'h00, 4'b0010);
        rd(8'h11);
        wr(8'h11, 8'h06);

        // Timeout on channel 2 with irq enabled
        wr(8'h20, 8'h09);
        repeat (260) rd(8'h21);
        n_checks++;
        if (rf_tx_start[2] !== 1'b0 || irq !== 1'b1) begin
            n_errors++;
            $display("FAIL ch2 timeout: start=%b irq=%b", rf_tx_start[2], irq);
        end
        rd(8'hF1);
        wr(8'h21, 8'h08);
        rd(8'h21);

        // Unmapped and out-of-range accesses
        wr(8'h7F, 8'hAA);
        n_checks++;
        if (write_flag !== 1'b0) begin
            n_errors++;
            $display("FAIL write_flag pulsed on unmapped write");
        end
        rd(8'h7F);
        wr(8'h46, 8'h01);
        rd(8'h46);
        wr(8'h0E, 8'hFF);
        rd(8'h0E);

        // done and W1C of done in the same cycle: set wins
        wr(8'h10, 8'h0B);
        rd(8'h11);
        step(1'b1, 8'h11, 8'h02, 4'b0010);
        rd(8'h11);
        rd(8'hF1);
        wr(8'h11, 8'h02);

        // Async reset while channel 0 is busy
        wr(8'h00, 8'h07);
        repeat (5) rd(8'h01);
        reset_step(8'h01);
        reset_step(8'hF0);
        resetn = 1'b1;
        rd(8'h00);

        // Randomized traffic
        for (int i = 0; i < 600; i++) begin
            logic [7:0] a, d;
            logic we;
            logic [N_CH-1:0] dn;
            int r = $urandom_range(0, 9);
            if (r < 7)       a = {4'($urandom_range(0, 4)), 4'($urandom_range(0, 15))};
            else if (r == 7) a = 8'hF0;
            else if (r == 8) a = 8'hF1;
            else             a = 8'($urandom);
            we = ($urandom_range(0, 9) < 6);
            d  = 8'($urandom);
            if (a[3:0] == 4'h0 && $urandom_range(0, 1) == 1) d[0] = 1'b1;
            for (int c = 0; c < N_CH; c++) dn[c] = ($urandom_range(0, 5) == 0);
            step(we, a, d, dn);
        end
        rd(8'hF1);

        if (n_errors == 0) $display("PASS");
        else $display("FAIL");
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
